// File: rtl/seg7_scan_ctrl.sv
// 8-digit multiplexed 7-segment scan controller with frame-synchronous commit.
// Optional digit blinking is built when SEG_BLINK_EN is defined.
module seg7_scan_ctrl #(
  parameter int DIV_W   = 17,
  parameter int BLINK_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_point,
  input  logic [7:0]  wr_le,
  input  logic [7:0]  blink_mask,
  output logic        wr_pend,
  output logic        frame_done,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT
);

  logic [DIV_W-1:0] r_presc;
  logic [2:0]       r_idx;
  logic [31:0]      r_act_data, r_stg_data;
  logic [7:0]       r_act_point, r_stg_point;
  logic [7:0]       r_act_le, r_stg_le;
  logic             r_wr_pend;
  logic             r_frame_done;
  logic [7:0]       r_an, r_seg;

  logic        w_tick, w_commit, w_blank;
  logic [2:0]  w_n;
  logic [31:0] w_act_data;
  logic [7:0]  w_act_point, w_act_le;
  logic [3:0]  w_nib;
  logic [7:0]  w_seg;

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_tick   = &r_presc;
  assign w_commit = w_tick && (r_idx == 3'd7);
  assign w_n      = r_idx + 3'd1;

  // A write landing on the commit edge bypasses the staged set
  always_comb begin
    w_act_data  = r_act_data;
    w_act_point = r_act_point;
    w_act_le    = r_act_le;
    if (w_commit) begin
      if (wr_en) begin
        w_act_data  = wr_data;
        w_act_point = wr_point;
        w_act_le    = wr_le;
      end else if (r_wr_pend) begin
        w_act_data  = r_stg_data;
        w_act_point = r_stg_point;
        w_act_le    = r_stg_le;
      end
    end
  end

  assign w_nib = w_act_data[{w_n, 2'b00} +: 4];

  always_comb begin
    w_seg = {~w_act_point[w_n],
             w_act_le[w_n] ? 7'h7F : dec(w_nib)};
    if (w_blank) w_seg = 8'hFF;
  end

`ifdef SEG_BLINK_EN
  logic [BLINK_W-1:0] r_blink;

  always_ff @(posedge clk) begin
    if (rst)               r_blink <= '0;
    else if (r_frame_done) r_blink <= r_blink + 1'b1;
  end

  assign w_blank = r_blink[BLINK_W-1] & blink_mask[w_n];
`else
  logic w_unused;
  assign w_unused = ^{blink_mask, {BLINK_W{1'b0}}};
  assign w_blank  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= 3'd7;
      r_act_data   <= '0;
      r_act_point  <= '0;
      r_act_le     <= 8'hFF;
      r_stg_data   <= '0;
      r_stg_point  <= '0;
      r_stg_le     <= 8'hFF;
      r_wr_pend    <= 1'b0;
      r_frame_done <= 1'b0;
      r_an         <= 8'hFF;
      r_seg        <= 8'hFF;
    end else begin
      r_presc      <= r_presc + 1'b1;
      r_frame_done <= w_commit;
      r_act_data   <= w_act_data;
      r_act_point  <= w_act_point;
      r_act_le     <= w_act_le;
      if (w_tick) begin
        r_idx <= w_n;
        r_an  <= ~(8'b1 << w_n);
        r_seg <= w_seg;
      end
      if (w_commit) begin
        r_wr_pend <= 1'b0;
      end else if (wr_en) begin
        r_stg_data  <= wr_data;
        r_stg_point <= wr_point;
        r_stg_le    <= wr_le;
        r_wr_pend   <= 1'b1;
      end
    end
  end

  assign wr_pend    = r_wr_pend;
  assign frame_done = r_frame_done;
  assign AN         = r_an;
  assign SEGMENT    = r_seg;

endmodule
